// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller: the per-slot
// scoreboard record, the forwarding-select encoding and the source-hit test.
package hazard_pkg;

    // Register addresses are carried zero-extended to this width inside the
    // scoreboard so the record type does not depend on a module parameter.
    localparam int REG_AW_MAX = 8;

    // Forwarding select value meaning "take the operand from the register file".
    localparam int FWD_REGFILE = 0;

    typedef logic [REG_AW_MAX-1:0] reg_addr_t;

    // One in-flight instruction as seen by the hazard logic.
    typedef struct packed {
        logic      valid;
        logic      wr;
        logic      load;
        reg_addr_t rd;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '0;

    // Width of a forwarding select for a scoreboard of the given depth.
    function automatic int fw_width(input int depth);
        return $clog2(depth);
    endfunction

    // A source hits a slot when that slot holds a live writer of a non-zero
    // register that the decode instruction actually reads.
    function automatic logic slot_hit(input slot_t s, input reg_addr_t src, input logic use_src);
        return s.valid && s.wr && (s.rd == src) && (src != '0) && use_src;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side bundle of the hazard controller: instruction descriptor and
// branch outcome in, pipeline write/bubble/flush controls and forwarding out.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int FW     = 2
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_wr_en;
    logic [REG_AW-1:0] id_rd;
    logic              id_is_load;
    logic              id_is_mc;
    logic              br_taken;

    logic              pc_write;
    logic              ifid_write;
    logic              idex_bubble;
    logic              ex_hold;
    logic              flush;
    logic [FW-1:0]     fwd_a;
    logic [FW-1:0]     fwd_b;

    // Decode stage / datapath side.
    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_rd,
               id_is_load, id_is_mc, br_taken,
        input  pc_write, ifid_write, idex_bubble, ex_hold, flush, fwd_a, fwd_b
    );

    // Hazard controller side.
    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_rd,
               id_is_load, id_is_mc, br_taken,
        output pc_write, ifid_write, idex_bubble, ex_hold, flush, fwd_a, fwd_b
    );
endinterface

// File: rtl/hazard_slot_tracker.sv
// Shift-register scoreboard of the instructions past decode. Slot 0 is EX,
// slot DEPTH-1 is WB. Supports inserting a bubble, holding EX while the
// multicycle unit is busy, and killing everything younger than the branch.
module hazard_slot_tracker
    import hazard_pkg::*;
#(
    parameter int DEPTH   = 3,
    parameter int BR_SLOT = 1
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  hold,
    input  logic  bubble,
    input  logic  inval,
    input  slot_t id_slot,
    output slot_t slots [DEPTH]
);

    slot_t slots_nxt [DEPTH];

    // Next scoreboard contents: flush first, then EX hold, then a plain shift.
    always_comb begin
        // NOTE: every element gets a default before any branch, so no latch can be inferred.
        for (int k = 0; k < DEPTH; k++) slots_nxt[k] = SLOT_BUBBLE;
        if (inval) begin
            // Old slots 0..BR_SLOT-1 are younger than the branch and die; the
            // decode instruction is never inserted.
            for (int k = 1; k < DEPTH; k++)
                if (k > BR_SLOT) slots_nxt[k] = slots[k-1];
        end else if (hold) begin
            // EX keeps its occupant, the stage behind it receives a bubble.
            slots_nxt[0] = slots[0];
            for (int k = 2; k < DEPTH; k++) slots_nxt[k] = slots[k-1];
        end else begin
            if (!bubble) slots_nxt[0] = id_slot;
            for (int k = 1; k < DEPTH; k++) slots_nxt[k] = slots[k-1];
        end
    end

    // Advance the scoreboard one pipeline step per clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: only the valid bits need reset; the payload of an invalid slot is never read.
            for (int k = 0; k < DEPTH; k++) slots[k].valid <= 1'b0;
        end else begin
            // NOTE: non-blocking, so every slot samples its neighbour's pre-edge value.
            for (int k = 0; k < DEPTH; k++) slots[k] <= slots_nxt[k];
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, multicycle structural stall,
// taken-branch flush and registered EX operand forwarding, all driven from a
// private scoreboard of in-flight destination registers.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW    = 5,   // up to REG_AW_MAX; register 0 reads as zero
    parameter int DEPTH     = 3,   // 2..8 tracked stages after decode
    parameter int LOAD_SLOT = 1,   // 1..DEPTH-1, load data ready at end of this slot
    parameter int BR_SLOT   = 1,   // 0..DEPTH-1, slot where branches resolve
    parameter int MC_LAT    = 4,   // 1..15 EX cycles of a multicycle op
    parameter int FW        = fw_width(DEPTH)
) (
    input logic               clk,
    input logic               reset,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int MCW = 4;

    slot_t             slots [DEPTH];
    slot_t             id_slot;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    reg_addr_t         rs;
    reg_addr_t         rt;
    logic [MCW-1:0]    mc_cnt;
    logic              mc_busy;
    logic              load_use;
    logic              stall;
    logic              insert;
    logic [FW-1:0]     sel_a;
    logic [FW-1:0]     sel_b;
    logic [FW-1:0]     fwd_a;
    logic [FW-1:0]     fwd_b;
    logic              pc_write;
    logic              ifid_write;
    logic              idex_bubble;
    logic              ex_hold;
    logic              flush;

    assign id_rs   = bus.id_rs;
    assign id_rt   = bus.id_rt;
    assign id_rd   = bus.id_rd;
    assign rs      = reg_addr_t'(id_rs);
    assign rt      = reg_addr_t'(id_rt);
    assign id_slot = '{valid: 1'b1, wr: bus.id_wr_en, load: bus.id_is_load, rd: reg_addr_t'(id_rd)};

    assign mc_busy = (mc_cnt != '0);
    assign stall   = bus.id_valid & (load_use | mc_busy);
    // A taken branch drops the decode instruction even if it would have stalled.
    assign insert  = bus.id_valid & ~stall & ~bus.br_taken;

    hazard_slot_tracker #(
        .DEPTH   (DEPTH),
        .BR_SLOT (BR_SLOT)
    ) u_tracker (
        .clk     (clk),
        .reset   (reset),
        .hold    (mc_busy),
        .bubble  (~insert),
        .inval   (bus.br_taken),
        .id_slot (id_slot),
        .slots   (slots)
    );

    // Load-use: a source depends on a load whose data is not ready in time.
    always_comb begin
        load_use = 1'b0;
        for (int k = 0; k < LOAD_SLOT; k++)
            if (slots[k].load && (slot_hit(slots[k], rs, bus.id_use_rs) ||
                                  slot_hit(slots[k], rt, bus.id_use_rt)))
                load_use = 1'b1;
    end

    // Forwarding select at decode: scan oldest to youngest so the youngest hit
    // wins. Slot k now is slot k+1 when the consumer reaches EX; the WB slot is
    // covered by the write-first register file.
    always_comb begin
        sel_a = FW'(FWD_REGFILE);
        sel_b = FW'(FWD_REGFILE);
        for (int k = DEPTH - 2; k >= 0; k--) begin
            if (slot_hit(slots[k], rs, bus.id_use_rs)) sel_a = FW'(k + 1);
            if (slot_hit(slots[k], rt, bus.id_use_rt)) sel_b = FW'(k + 1);
        end
    end

    // Pipeline controls: reset overrides everything, flush overrides stall.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ex_hold     = mc_busy;
        flush       = 1'b0;
        if (reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            ex_hold     = 1'b0;
            flush       = 1'b1;
        end else if (bus.br_taken) begin
            flush = 1'b1;
        end else if (stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = load_use & ~mc_busy;
        end
    end

    // Multicycle occupancy counter; a flush that kills EX also kills the op.
    always_ff @(posedge clk) begin
        if (reset) begin
            mc_cnt <= '0;
        end else if (bus.br_taken && (BR_SLOT > 0)) begin
            mc_cnt <= '0;
        end else if (insert && bus.id_is_mc) begin
            mc_cnt <= MCW'(MC_LAT - 1);
        end else if (mc_busy) begin
            mc_cnt <= mc_cnt - 1'b1;
        end
    end

    // Forwarding selects follow the instruction into EX; frozen while EX is held.
    always_ff @(posedge clk) begin
        if (reset || bus.br_taken) begin
            fwd_a <= FW'(FWD_REGFILE);
            fwd_b <= FW'(FWD_REGFILE);
        end else if (mc_busy) begin
            fwd_a <= fwd_a;
            fwd_b <= fwd_b;
        end else if (insert) begin
            fwd_a <= sel_a;
            fwd_b <= sel_b;
        end else begin
            fwd_a <= FW'(FWD_REGFILE);
            fwd_b <= FW'(FWD_REGFILE);
        end
    end

    assign bus.pc_write    = pc_write;
    assign bus.ifid_write  = ifid_write;
    assign bus.idex_bubble = idex_bubble;
    assign bus.ex_hold     = ex_hold;
    assign bus.flush       = flush;
    assign bus.fwd_a       = fwd_a;
    assign bus.fwd_b       = fwd_b;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Two instances share one decode stream:
// dut_a uses the default parameters, dut_b uses DEPTH=5, LOAD_SLOT=2.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_use_rs, id_use_rt, id_wr_en, id_is_load, id_is_mc, br_taken;
    logic [4:0] id_rs, id_rt, id_rd;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_AW(5), .FW(2)) bus_a ();
    pipe_hazard_ctrl_if #(.REG_AW(5), .FW(3)) bus_b ();

    assign bus_a.id_valid   = id_valid;
    assign bus_a.id_rs      = id_rs;
    assign bus_a.id_rt      = id_rt;
    assign bus_a.id_use_rs  = id_use_rs;
    assign bus_a.id_use_rt  = id_use_rt;
    assign bus_a.id_wr_en   = id_wr_en;
    assign bus_a.id_rd      = id_rd;
    assign bus_a.id_is_load = id_is_load;
    assign bus_a.id_is_mc   = id_is_mc;
    assign bus_a.br_taken   = br_taken;

    assign bus_b.id_valid   = id_valid;
    assign bus_b.id_rs      = id_rs;
    assign bus_b.id_rt      = id_rt;
    assign bus_b.id_use_rs  = id_use_rs;
    assign bus_b.id_use_rt  = id_use_rt;
    assign bus_b.id_wr_en   = id_wr_en;
    assign bus_b.id_rd      = id_rd;
    assign bus_b.id_is_load = id_is_load;
    assign bus_b.id_is_mc   = id_is_mc;
    assign bus_b.br_taken   = br_taken;

    pipe_hazard_ctrl #(
        .REG_AW(5), .DEPTH(3), .LOAD_SLOT(1), .BR_SLOT(1), .MC_LAT(4), .FW(2)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    pipe_hazard_ctrl #(
        .REG_AW(5), .DEPTH(5), .LOAD_SLOT(2), .BR_SLOT(1), .MC_LAT(4), .FW(3)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One decode cycle: wait for the falling edge, present the instruction, settle.
    task automatic drive(input logic v, input logic [4:0] rd, input logic [4:0] rs,
                         input logic [4:0] rt, input logic urs, input logic urt,
                         input logic wr, input logic ld, input logic mc, input logic br);
        @(negedge clk);
        id_valid   = v;
        id_rd      = rd;
        id_rs      = rs;
        id_rt      = rt;
        id_use_rs  = urs;
        id_use_rt  = urt;
        id_wr_en   = wr;
        id_is_load = ld;
        id_is_mc   = mc;
        br_taken   = br;
        #1;
    endtask

    task automatic nop(input logic br = 1'b0);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, br);
    endtask

    task automatic alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                       input logic br = 1'b0);
        drive(1'b1, rd, rs, rt, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, br);
    endtask

    task automatic load(input logic [4:0] rd, input logic [4:0] rs);
        drive(1'b1, rd, rs, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic mul(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        drive(1'b1, rd, rs, rt, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        reset      = 1'b1;
        id_valid   = 1'b0;
        id_rd      = '0;
        id_rs      = '0;
        id_rt      = '0;
        id_use_rs  = 1'b0;
        id_use_rt  = 1'b0;
        id_wr_en   = 1'b0;
        id_is_load = 1'b0;
        id_is_mc   = 1'b0;
        br_taken   = 1'b0;

        // Reset outputs and state.
        nop();
        check("rst_pc_write",    bus_a.pc_write, 0);
        check("rst_ifid_write",  bus_a.ifid_write, 0);
        check("rst_idex_bubble", bus_a.idex_bubble, 1);
        check("rst_ex_hold",     bus_a.ex_hold, 0);
        check("rst_flush",       bus_a.flush, 1);
        check("rst_fwd_a",       bus_a.fwd_a, 0);
        check("rst_fwd_b",       bus_a.fwd_b, 0);
        nop();
        reset = 1'b0;
        #1;
        check("clean_pc_write", bus_a.pc_write, 1);
        check("clean_flush",    bus_a.flush, 0);

        // 1. Back-to-back ALU dependence, one-gap dependence, rt dependence.
        alu(5'd3, 5'd1, 5'd2);
        check("c1_pc_write", bus_a.pc_write, 1);
        alu(5'd5, 5'd3, 5'd1);
        check("b2b_no_stall",  bus_a.pc_write, 1);
        check("b2b_no_bubble", bus_a.idex_bubble, 0);
        nop();
        check("b2b_fwd_a", bus_a.fwd_a, 1);
        check("b2b_fwd_b", bus_a.fwd_b, 0);
        alu(5'd3, 5'd1, 5'd2);
        check("bubble_fwd_a", bus_a.fwd_a, 0);
        nop();
        alu(5'd5, 5'd3, 5'd1);
        nop();
        check("gap1_fwd_a", bus_a.fwd_a, 2);
        alu(5'd3, 5'd1, 5'd2);
        alu(5'd6, 5'd1, 5'd3);
        nop();
        check("rt_fwd_a", bus_a.fwd_a, 0);
        check("rt_fwd_b", bus_a.fwd_b, 1);

        // 2. Load-use: exactly one stall cycle, then forward from WB.
        load(5'd4, 5'd1);
        alu(5'd5, 5'd4, 5'd4);
        check("lu_pc_write",    bus_a.pc_write, 0);
        check("lu_ifid_write",  bus_a.ifid_write, 0);
        check("lu_idex_bubble", bus_a.idex_bubble, 1);
        alu(5'd5, 5'd4, 5'd4);
        check("lu_release_pc", bus_a.pc_write, 1);
        check("lu_release_bb", bus_a.idex_bubble, 0);
        nop();
        check("lu_fwd_a", bus_a.fwd_a, 2);
        check("lu_fwd_b", bus_a.fwd_b, 2);
        load(5'd4, 5'd1);
        nop();
        alu(5'd5, 5'd4, 5'd4);
        check("lu_gap_no_stall", bus_a.pc_write, 1);
        nop();
        check("lu_gap_fwd_a", bus_a.fwd_a, 2);

        // 3. Register 0 never forwards or stalls.
        alu(5'd0, 5'd1, 5'd2);
        alu(5'd5, 5'd0, 5'd0);
        check("r0_no_stall", bus_a.pc_write, 1);
        nop();
        check("r0_fwd_a", bus_a.fwd_a, 0);
        check("r0_fwd_b", bus_a.fwd_b, 0);
        load(5'd0, 5'd1);
        alu(5'd5, 5'd0, 5'd0);
        check("r0_ld_no_stall",  bus_a.pc_write, 1);
        check("r0_ld_no_bubble", bus_a.idex_bubble, 0);
        nop();
        check("r0_ld_fwd_a", bus_a.fwd_a, 0);

        // 4. Multicycle op holds EX for MC_LAT-1 cycles.
        mul(5'd6, 5'd1, 5'd2);
        alu(5'd7, 5'd1, 5'd2);
        check("mc1_ex_hold",    bus_a.ex_hold, 1);
        check("mc1_pc_write",   bus_a.pc_write, 0);
        check("mc1_ifid_write", bus_a.ifid_write, 0);
        check("mc1_idex_bb",    bus_a.idex_bubble, 0);
        alu(5'd7, 5'd1, 5'd2);
        check("mc2_ex_hold", bus_a.ex_hold, 1);
        alu(5'd7, 5'd1, 5'd2);
        check("mc3_ex_hold",  bus_a.ex_hold, 1);
        check("mc3_pc_write", bus_a.pc_write, 0);
        alu(5'd7, 5'd1, 5'd2);
        check("mc4_ex_hold",  bus_a.ex_hold, 0);
        check("mc4_pc_write", bus_a.pc_write, 1);
        mul(5'd6, 5'd7, 5'd2);
        check("mc_add_fwd_a", bus_a.fwd_a, 0);
        alu(5'd8, 5'd6, 5'd1);
        check("mcd_ex_hold", bus_a.ex_hold, 1);
        check("mcd_mul_fwd", bus_a.fwd_a, 1);
        alu(5'd8, 5'd6, 5'd1);
        alu(5'd8, 5'd6, 5'd1);
        check("mcd_hold_fwd", bus_a.fwd_a, 1);
        alu(5'd8, 5'd6, 5'd1);
        check("mcd_release", bus_a.pc_write, 1);
        nop();
        check("mcd_fwd_a", bus_a.fwd_a, 1);
        check("mcd_fwd_b", bus_a.fwd_b, 0);

        // 5. Flush beats a load-use stall and kills younger work.
        load(5'd4, 5'd1);
        alu(5'd5, 5'd4, 5'd1, 1'b1);
        check("fl_flush",       bus_a.flush, 1);
        check("fl_pc_write",    bus_a.pc_write, 1);
        check("fl_ifid_write",  bus_a.ifid_write, 1);
        check("fl_idex_bubble", bus_a.idex_bubble, 0);
        alu(5'd5, 5'd4, 5'd1);
        check("fl_after_pc", bus_a.pc_write, 1);
        check("fl_after_fwd", bus_a.fwd_a, 0);
        nop();
        check("fl_killed_fwd_a", bus_a.fwd_a, 0);
        mul(5'd6, 5'd1, 5'd2);
        nop(1'b1);
        check("flmc_ex_hold", bus_a.ex_hold, 1);
        check("flmc_flush",   bus_a.flush, 1);
        nop();
        check("flmc_cnt",     dut_a.mc_cnt, 0);
        check("flmc_no_hold", bus_a.ex_hold, 0);

        // 6. Reset in the middle of a multicycle op.
        mul(5'd6, 5'd1, 5'd2);
        nop();
        nop();
        check("rmc_cnt_before", dut_a.mc_cnt, 2);
        reset = 1'b1;
        #1;
        check("rmc_pc_write",    bus_a.pc_write, 0);
        check("rmc_ifid_write",  bus_a.ifid_write, 0);
        check("rmc_idex_bubble", bus_a.idex_bubble, 1);
        check("rmc_ex_hold",     bus_a.ex_hold, 0);
        check("rmc_flush",       bus_a.flush, 1);
        alu(5'd5, 5'd6, 5'd6);
        reset = 1'b0;
        #1;
        check("rmc_cnt_after", dut_a.mc_cnt, 0);
        check("rmc_hold_off",  bus_a.ex_hold, 0);
        check("rmc_fwd_a",     bus_a.fwd_a, 0);
        check("rmc_pc_free",   bus_a.pc_write, 1);
        nop();
        check("rmc_slots_fwd_a", bus_a.fwd_a, 0);
        check("rmc_slots_fwd_b", bus_a.fwd_b, 0);
        check("b_rst_fwd_a",     bus_b.fwd_a, 0);

        // Deep pipeline (dut_b): forwarding distance 1..4 and the WB boundary.
        alu(5'd3, 5'd1, 5'd2);
        alu(5'd5, 5'd3, 5'd1);
        check("b_b2b_no_stall", bus_b.pc_write, 1);
        nop();
        check("b_b2b_fwd_a", bus_b.fwd_a, 1);
        alu(5'd3, 5'd1, 5'd2);
        nop();
        alu(5'd5, 5'd3, 5'd1);
        nop();
        check("b_gap1_fwd_a", bus_b.fwd_a, 2);
        alu(5'd3, 5'd1, 5'd2);
        nop();
        nop();
        alu(5'd5, 5'd3, 5'd1);
        nop();
        check("b_gap2_fwd_a", bus_b.fwd_a, 3);
        alu(5'd3, 5'd1, 5'd2);
        nop();
        nop();
        nop();
        alu(5'd5, 5'd3, 5'd1);
        nop();
        check("b_gap3_fwd_a", bus_b.fwd_a, 4);
        alu(5'd3, 5'd1, 5'd2);
        nop();
        nop();
        nop();
        nop();
        alu(5'd5, 5'd3, 5'd1);
        nop();
        check("b_wb_fwd_a", bus_b.fwd_a, 0);

        // Deep pipeline load-use: back-to-back stalls two cycles, one gap stalls one.
        load(5'd4, 5'd1);
        alu(5'd5, 5'd4, 5'd4);
        check("b_lu1_pc_write", bus_b.pc_write, 0);
        check("b_lu1_bubble",   bus_b.idex_bubble, 1);
        alu(5'd5, 5'd4, 5'd4);
        check("b_lu2_pc_write", bus_b.pc_write, 0);
        check("b_lu2_bubble",   bus_b.idex_bubble, 1);
        alu(5'd5, 5'd4, 5'd4);
        check("b_lu3_pc_write", bus_b.pc_write, 1);
        nop();
        check("b_lu_fwd_a", bus_b.fwd_a, 3);
        check("b_lu_fwd_b", bus_b.fwd_b, 3);
        load(5'd4, 5'd1);
        nop();
        alu(5'd5, 5'd4, 5'd4);
        check("b_lug_pc_write",   bus_b.pc_write, 0);
        check("b_lug_ifid_write", bus_b.ifid_write, 0);
        check("b_lug_bubble",     bus_b.idex_bubble, 1);
        alu(5'd5, 5'd4, 5'd4);
        check("b_lug_release", bus_b.pc_write, 1);
        nop();
        check("b_lug_fwd_a", bus_b.fwd_a, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
